// File: rtl/min_max_reduce_pipe.sv
// min_max_reduce_pipe: pipelined min/max reduction tree over NUM_INPUTS lane
// counters. Returns the winning value, its lane index and the request tag.
// Stage 0 registers the request. Each later stage halves the live element
// count, rounding up. All stages advance together on a single global enable.
module min_max_reduce_pipe #(
  parameter int NUM_INPUTS = 4,
  parameter int ADDR_SIZE  = 22,
  parameter int CNT_SIZE   = 32,
  parameter int IDX_SIZE   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  query_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_SIZE-1:0]  in_addr,
  input  logic [CNT_SIZE-1:0]   in_cnt_array [0:NUM_INPUTS-1],
  input  logic [NUM_INPUTS-1:0] in_mask,
  input  logic                  in_mode_max,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_SIZE-1:0]  out_addr,
  output logic [CNT_SIZE-1:0]   out_cnt,
  output logic [IDX_SIZE-1:0]   out_idx,
  output logic                  out_none,
  output logic                  out_mode_max
);

  localparam int LEVELS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
  localparam int LAT    = LEVELS + 1;

  typedef struct packed {
    logic                vld;
    logic [IDX_SIZE-1:0] idx;
    logic [CNT_SIZE-1:0] val;
  } elem_t;

  // Number of live elements held in stage s.
  function automatic int count_at(input int s);
    return (NUM_INPUTS + (1 << s) - 1) >> s;
  endfunction

  // Merge two elements. a always carries the lower index, so ties keep a.
  function automatic elem_t combine(input elem_t a, input elem_t b, input logic mode_max);
    elem_t r;
    r = '0;
    case ({a.vld, b.vld})
      2'b10:   r = a;
      2'b01:   r = b;
      2'b11: begin
        if (mode_max) r = (b.val > a.val) ? b : a;
        else          r = (b.val < a.val) ? b : a;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  elem_t                elem_q [LAT][NUM_INPUTS];
  elem_t                elem_d [LAT][NUM_INPUTS];
  logic                 vld_q  [LAT];
  logic                 vld_d  [LAT];
  logic                 mode_q [LAT];
  logic                 mode_d [LAT];
  logic [ADDR_SIZE-1:0] addr_q [LAT];
  logic [ADDR_SIZE-1:0] addr_d [LAT];

  // red[s] holds the combinational inputs of stage s+1. red[LEVELS] is tied off.
  elem_t red [LAT][NUM_INPUTS];

  logic  en;
  logic  xfer;
  elem_t fin;

  for (genvar s = 0; s < LAT; s++) begin : g_lvl
    localparam int NCUR = count_at(s);
    localparam int NNXT = count_at(s + 1);
    for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_el
      if (s == LEVELS || j >= NNXT) begin : g_zero
        assign red[s][j] = '0;
      end else if (2 * j + 1 < NCUR) begin : g_pair
        assign red[s][j] = combine(elem_q[s][2*j], elem_q[s][2*j+1], mode_q[s]);
      end else begin : g_pass
        // Odd element count: the last element passes through unchanged.
        assign red[s][j] = elem_q[s][2*j];
      end
    end
  end

  assign en   = !vld_q[LAT-1] || out_ready;
  assign xfer = in_valid && in_ready;
  assign fin  = elem_q[LAT-1][0];

  // Next-state for every stage. A flush wins over shifting and capture.
  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    addr_d = addr_q;
    elem_d = elem_q;
    if (!query_rst_n) begin
      for (int unsigned s = 0; s < LAT; s++) begin
        vld_d[s]  = 1'b0;
        mode_d[s] = 1'b0;
        addr_d[s] = '0;
        for (int unsigned j = 0; j < NUM_INPUTS; j++) elem_d[s][j] = '0;
      end
    end else if (en) begin
      vld_d[0]  = xfer;
      mode_d[0] = xfer && in_mode_max;
      addr_d[0] = xfer ? in_addr : '0;
      for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
        elem_d[0][j] = '0;
        if (xfer && in_mask[j]) begin
          elem_d[0][j].vld = 1'b1;
          elem_d[0][j].idx = IDX_SIZE'(j);
          elem_d[0][j].val = in_cnt_array[j];
        end
      end
      for (int unsigned s = 1; s < LAT; s++) begin
        vld_d[s]  = vld_q[s-1];
        mode_d[s] = mode_q[s-1];
        addr_d[s] = addr_q[s-1];
        for (int unsigned j = 0; j < NUM_INPUTS; j++) elem_d[s][j] = red[s-1][j];
      end
    end
  end

  // Stage registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < LAT; s++) begin
        vld_q[s]  <= 1'b0;
        mode_q[s] <= 1'b0;
        addr_q[s] <= '0;
        for (int unsigned j = 0; j < NUM_INPUTS; j++) elem_q[s][j] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      addr_q <= addr_d;
      elem_q <= elem_d;
    end
  end

  // Outputs are forced to zero while a flush or reset is asserted.
  always_comb begin
    in_ready     = rst_n && query_rst_n && en;
    out_valid    = query_rst_n && vld_q[LAT-1];
    out_addr     = query_rst_n ? addr_q[LAT-1] : '0;
    out_cnt      = (query_rst_n && fin.vld) ? fin.val : '0;
    out_idx      = (query_rst_n && fin.vld) ? fin.idx : '0;
    out_none     = query_rst_n && vld_q[LAT-1] && !fin.vld;
    out_mode_max = query_rst_n && mode_q[LAT-1];
  end

endmodule

// File: tb/tb_min_max_reduce_pipe.sv
// Scoreboard bench for min_max_reduce_pipe. It drives two instances:
// NUM_INPUTS=4 (g=0) and NUM_INPUTS=5 (g=1, which has an odd-lane pass-through).
module tb_min_max_reduce_pipe;

  localparam int AW   = 22;
  localparam int CW   = 32;
  localparam int NMAX = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          none;
    logic          mode;
    int            cyc;
    bit            strict;
  } exp_t;

  exp_t exp_q [2][$];

  logic clk;
  logic rst_n;
  logic qrst_n;
  logic          vin   [2];
  logic [NMAX-1:0] msk [2];
  logic          md    [2];
  logic [AW-1:0] ad    [2];
  logic [CW-1:0] cn    [2][NMAX];
  logic          ordy  [2];
  logic          irdy  [2];
  logic          ov    [2];
  logic [AW-1:0] oa    [2];
  logic [CW-1:0] oc    [2];
  logic [2:0]    oi    [2];
  logic          onone [2];
  logic          om    [2];

  int n_cmp;
  int n_bad;
  int cyc;
  bit strict_lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: scan the lanes in index order and keep the first strictly better value.
  function automatic exp_t model(input int g);
    exp_t e;
    int   n;
    bit   found;
    n = (g == 0) ? 4 : 5;
    found = 0;
    e.addr = ad[g];
    e.mode = md[g];
    e.cnt = '0;
    e.idx = '0;
    e.cyc = cyc;
    e.strict = strict_lat;
    for (int i = 0; i < n; i++) begin
      if (msk[g][i]) begin
        if (!found || (md[g] ? (cn[g][i] > e.cnt) : (cn[g][i] < e.cnt))) begin
          e.cnt = cn[g][i];
          e.idx = 3'(i);
          found = 1;
        end
      end
    end
    e.none = !found;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int NI  = (g == 0) ? 4 : 5;
    localparam int IW  = $clog2(NI);
    localparam int LAT = 1 + $clog2(NI);
    logic [IW-1:0] idx_w;
    logic [CW-1:0] cs [0:NI-1];

    always_comb for (int i = 0; i < NI; i++) cs[i] = cn[g][i];
    assign oi[g] = 3'(idx_w);

    min_max_reduce_pipe #(
      .NUM_INPUTS (NI),
      .ADDR_SIZE  (AW),
      .CNT_SIZE   (CW)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .query_rst_n  (qrst_n),
      .in_valid     (vin[g]),
      .in_ready     (irdy[g]),
      .in_addr      (ad[g]),
      .in_cnt_array (cs),
      .in_mask      (msk[g][NI-1:0]),
      .in_mode_max  (md[g]),
      .out_valid    (ov[g]),
      .out_ready    (ordy[g]),
      .out_addr     (oa[g]),
      .out_cnt      (oc[g]),
      .out_idx      (idx_w),
      .out_none     (onone[g]),
      .out_mode_max (om[g])
    );

    // Monitor: sample 1 time unit before each rising edge, pop on output handshakes.
    logic        held;
    logic [59:0] snap;
    exp_t        e;
    initial held = 1'b0;
    always begin
      @(negedge clk);
      #4;
      if (!rst_n || !qrst_n) begin
        chk($sformatf("g%0d_outputs_zero_in_reset", g),
            64'({ov[g], oa[g], oc[g], oi[g], onone[g], om[g], irdy[g]}), 64'd0);
        exp_q[g].delete();
        held = 1'b0;
      end else begin
        if (held)
          chk($sformatf("g%0d_stall_hold", g),
              64'({ov[g], oa[g], oc[g], oi[g], onone[g], om[g]}), 64'(snap));
        if (ov[g] && !ordy[g])
          chk($sformatf("g%0d_in_ready_stall", g), 64'(irdy[g]), 64'd0);
        if (ov[g] && ordy[g]) begin
          if (exp_q[g].size() == 0) begin
            chk($sformatf("g%0d_unexpected_output", g), 64'(ov[g]), 64'd0);
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("g%0d_addr", g), 64'(oa[g]), 64'(e.addr));
            chk($sformatf("g%0d_cnt", g), 64'(oc[g]), 64'(e.cnt));
            chk($sformatf("g%0d_idx", g), 64'(oi[g]), 64'(e.idx));
            chk($sformatf("g%0d_none", g), 64'(onone[g]), 64'(e.none));
            chk($sformatf("g%0d_mode", g), 64'(om[g]), 64'(e.mode));
            if (e.strict)
              chk($sformatf("g%0d_latency", g), 64'(cyc - e.cyc), 64'(LAT));
            else
              chk($sformatf("g%0d_latency_min", g), 64'((cyc - e.cyc) >= LAT), 64'd1);
          end
        end
        held = ov[g] && !ordy[g];
        snap = {ov[g], oa[g], oc[g], oi[g], onone[g], om[g]};
      end
    end
  end

  // Called at a falling edge: record transfers just before the rising edge, return at the next falling edge.
  task automatic step(output bit [1:0] f);
    #4;
    f = '0;
    for (int g = 0; g < 2; g++) begin
      if (vin[g] && irdy[g]) begin
        f[g] = 1'b1;
        exp_q[g].push_back(model(g));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    bit [1:0] f;
    step(f);
  endtask

  // Issue one cycle with the given valids; every valid request must be accepted.
  task automatic issue(input bit v0, input bit v1);
    bit [1:0] f;
    vin[0] = v0;
    vin[1] = v1;
    step(f);
    if (v0) chk("g0_accept", 64'(f[0]), 64'd1);
    if (v1) chk("g1_accept", 64'(f[1]), 64'd1);
    vin[0] = 1'b0;
    vin[1] = 1'b0;
  endtask

  task automatic set_req(input int g, input logic [AW-1:0] a, input logic m, input logic [NMAX-1:0] mk,
                         input logic [CW-1:0] c0, input logic [CW-1:0] c1, input logic [CW-1:0] c2,
                         input logic [CW-1:0] c3, input logic [CW-1:0] c4);
    ad[g] = a;
    md[g] = m;
    msk[g] = mk;
    cn[g][0] = c0;
    cn[g][1] = c1;
    cn[g][2] = c2;
    cn[g][3] = c3;
    cn[g][4] = c4;
  endtask

  task automatic rand_req(input int g);
    ad[g] = AW'($urandom);
    md[g] = 1'($urandom);
    msk[g] = ($urandom_range(0, 3) == 0) ? NMAX'($urandom) : '1;
    for (int i = 0; i < NMAX; i++)
      cn[g][i] = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 7)) : CW'($urandom);
  endtask

  task automatic drain();
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    for (int k = 0; k < 40 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); k++) tick();
    chk("g0_drain_empty", 64'(exp_q[0].size()), 64'd0);
    chk("g1_drain_empty", 64'(exp_q[1].size()), 64'd0);
  endtask

  initial begin
    bit [1:0] f;
    int issued [2];
    int stall [2];
    bit seen [2];
    n_cmp = 0;
    n_bad = 0;
    strict_lat = 1'b1;
    rst_n = 1'b0;
    qrst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      vin[g] = 1'b0;
      ordy[g] = 1'b1;
      set_req(g, '0, 1'b0, '0, 0, 0, 0, 0, 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Min over {7,3,9,3}: tie at 3 resolves to lane 1.
    set_req(0, 22'h12345, 1'b0, 5'h0F, 7, 3, 9, 3, 0);
    issue(1, 0);
    drain();

    // N=5: max then min back-to-back; the min winner is the odd pass-through lane 4.
    set_req(1, 22'h00abc, 1'b1, 5'h1F, 4, 10, 2, 10, 1);
    issue(0, 1);
    set_req(1, 22'h00abd, 1'b0, 5'h1F, 4, 10, 2, 10, 1);
    issue(0, 1);
    drain();

    // Masked lanes, and the all-masked case on both instances.
    set_req(0, 22'h00011, 1'b0, 5'b01110, 1, 5, 6, 7, 0);
    issue(1, 0);
    set_req(0, 22'h00022, 1'b0, 5'b00000, 1, 5, 6, 7, 0);
    set_req(1, 22'h00033, 1'b1, 5'b00000, 9, 9, 9, 9, 9);
    issue(1, 1);
    set_req(1, 22'h00044, 1'b1, 5'b10000, 9, 9, 9, 9, 2);
    issue(0, 1);
    drain();

    // Six back-to-back requests; stall 4 cycles once the first result appears.
    strict_lat = 1'b0;
    for (int g = 0; g < 2; g++) begin
      issued[g] = 0;
      stall[g] = 0;
      seen[g] = 0;
      rand_req(g);
      vin[g] = 1'b1;
    end
    for (int k = 0; k < 60 && (issued[0] < 6 || issued[1] < 6); k++) begin
      for (int g = 0; g < 2; g++) begin
        if (!seen[g] && ov[g]) begin
          seen[g] = 1;
          stall[g] = 4;
        end
        ordy[g] = (stall[g] == 0);
        if (stall[g] > 0) stall[g]--;
      end
      step(f);
      for (int g = 0; g < 2; g++) begin
        if (f[g]) begin
          issued[g]++;
          if (issued[g] < 6) rand_req(g);
          else vin[g] = 1'b0;
        end
      end
    end
    chk("g0_burst_issued", 64'(issued[0]), 64'd6);
    chk("g1_burst_issued", 64'(issued[1]), 64'd6);
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    drain();

    // Flush with three requests in flight; nothing stale may appear afterwards.
    for (int k = 0; k < 3; k++) begin
      rand_req(0);
      rand_req(1);
      issue(1, 1);
    end
    qrst_n = 1'b0;
    tick();
    qrst_n = 1'b1;
    repeat (8) tick();
    chk("g0_flush_empty", 64'(exp_q[0].size()), 64'd0);
    strict_lat = 1'b1;
    rand_req(0);
    rand_req(1);
    issue(1, 1);
    drain();

    // Asynchronous reset between clock edges in the middle of a stream.
    strict_lat = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_req(0);
      rand_req(1);
      vin[0] = 1'b1;
      vin[1] = 1'b1;
      step(f);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++)
      chk($sformatf("g%0d_async_reset_now", g),
          64'({ov[g], oa[g], oc[g], oi[g], onone[g], om[g], irdy[g]}), 64'd0);
    @(negedge clk);
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("g0_ready_after_reset", 64'(irdy[0]), 64'd1);
    chk("g1_ready_after_reset", 64'(irdy[1]), 64'd1);
    @(negedge clk);
    strict_lat = 1'b1;
    rand_req(0);
    rand_req(1);
    issue(1, 1);
    drain();

    // Random traffic with random backpressure and occasional flushes.
    strict_lat = 1'b0;
    for (int k = 0; k < 600; k++) begin
      for (int g = 0; g < 2; g++) begin
        rand_req(g);
        vin[g] = ($urandom_range(0, 2) != 0);
        ordy[g] = ($urandom_range(0, 3) != 0);
      end
      qrst_n = ($urandom_range(0, 79) != 0);
      step(f);
    end
    qrst_n = 1'b1;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/min_max_reduce_pipe.md
Name: min_max_reduce_pipe

Overview:
- Pipelined reduction tree that returns the minimum or maximum of NUM_INPUTS counter values, plus the winning lane index, alongside a tagged address.
- Generalises the count-min sketch min stage:
  - any lane count, not only powers of 2;
  - per-request min/max mode;
  - per-lane mask;
  - winner index output;
  - ready/valid backpressure.
- Sits between the hash-bank count readout and the sketch query/update logic in the AFU.

Parameters:
NUM_INPUTS, 4, number of counter lanes (>=1; any integer).
ADDR_SIZE, 22, width of the address tag carried with each request.
CNT_SIZE, 32, counter width.
IDX_SIZE, $clog2(NUM_INPUTS) (min 1), width of out_idx (derived, not to be overridden).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
query_rst_n  in  1  synchronous active-low flush of the pipeline.
in_valid  in  1  request valid.
in_ready  out  1  block accepts a request this cycle.
in_addr  in  ADDR_SIZE  address tag.
in_cnt_array  in  CNT_SIZE x [0:NUM_INPUTS-1]  lane counts (unpacked array).
in_mask  in  NUM_INPUTS  1 = lane participates; 0 = lane excluded.
in_mode_max  in  1  0 = minimum, 1 = maximum.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_addr  out  ADDR_SIZE  tag of the result.
out_cnt  out  CNT_SIZE  reduced value.
out_idx  out  IDX_SIZE  lane index of the winner.
out_none  out  1  all lanes were masked.
out_mode_max  out  1  mode the result was computed in.

Behaviour:
- Pipeline depth: LAT = 1 + $clog2(NUM_INPUTS) register stages.
  - Stage 0 captures the inputs.
  - Each following stage halves the live element count, rounding up.
  - For NUM_INPUTS=1, LAT=1.
- Odd element count at a stage: the last element passes through unchanged to the next stage, with its index and lane-valid.
- Each element carries value, index and lane-valid. Combining two elements a (lower index) and b:
  - both invalid -> invalid, value 0, idx 0;
  - exactly one valid -> that element;
  - both valid, min mode -> b if b < a, else a;
  - both valid, max mode -> b if b > a, else a;
  - ties therefore always resolve to the lower index.
- Mode, addr and valid travel with each request; every stage uses that stage's captured mode.
- out_none = 1 when the final element is invalid; then out_cnt = 0 and out_idx = 0.
- Flow control: global enable en = !out_valid_q || out_ready.
  - All stages shift only when en = 1; bubbles shift with the pipe and are not collapsed.
  - in_ready = en && query_rst_n.
  - A transfer occurs on in_valid && in_ready.
  - While en = 0, all stage registers hold, including output data.
  - When the pipe is full, throughput is 1 request per cycle.
- Stage 0 loads valid = 0 and zero data when no transfer occurs.
- rst_n low (asynchronous): all stage valid bits and data go to 0. out_valid=0, out_addr=0, out_cnt=0, out_idx=0, out_none=0, out_mode_max=0; in_ready=0 while reset is asserted.
- query_rst_n low:
  - synchronously clears all stage valid bits and data on the next edge, with priority over en and input capture;
  - combinationally forces every output (including in_ready) to 0 while asserted;
  - requests in flight are dropped, with no partial results.
- Reset mid-stall: pending output is lost; after release, the pipe is empty and in_ready=1.
- Arithmetic: unsigned compares only; no saturation or overflow is possible.

Test Plan:
- Min, N=4, mask=4'hF, cnts {7,3,9,3}, addr=0x12345, out_ready=1 -> 3 cycles later: out_valid=1, out_cnt=3, out_idx=1, out_addr=0x12345, out_none=0.
- Max, N=5, mask=5'h1F, cnts {4,10,2,10,1} -> after LAT=4: out_cnt=10, out_idx=1. Then min mode, cnts {4,10,2,10,1} on the next cycle -> the next result is out_cnt=1, out_idx=4 (odd pass-through lane).
- Mask: N=4, min, cnts {1,5,6,7}, mask=4'b1110 -> out_cnt=5, out_idx=1. Mask=4'b0000 -> out_none=1, out_cnt=0, out_idx=0.
- Backpressure: stream 6 back-to-back requests, hold out_ready=0 for 4 cycles once the first result appears.
  - in_ready=0 during the stall; out_* is stable.
  - All 6 results emerge in order with no loss or duplication.
- Flush: 3 requests in flight, pulse query_rst_n low for 1 cycle.
  - Outputs are 0 during the pulse and no stale result ever appears afterwards.
  - The next request returns correctly after LAT cycles.
- Async reset: assert rst_n mid-stream between clock edges -> all outputs are 0 immediately; after release the first request produces correct results.
